// File: rtl/target_reset_sched.sv
// Round-robin scheduler for the shared target resetter: fires a one-cycle enable,
// tracks the reset line low then high, waits for boot settle, and answers the owner.
module target_reset_sched #(
    parameter int NUM_REQ       = 3,
    parameter int LOW_TIMEOUT   = 16,
    parameter int HOLD_MAX      = 25_000_000,
    parameter int SETTLE_CYCLES = 1_200_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               done,
    output logic               err,
    output logic               busy,
    output logic               rst_enable,
    input  logic               rst_line_in,
    output logic [15:0]        reset_count
);
    localparam int MAX_A = (LOW_TIMEOUT > HOLD_MAX) ? LOW_TIMEOUT : HOLD_MAX;
    localparam int MAX_C = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
    localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [NUM_REQ-1:0] ONE         = NUM_REQ'(1);
    localparam logic [CW-1:0]      LOW_LAST    = CW'(LOW_TIMEOUT - 1);
    localparam logic [CW-1:0]      HOLD_LAST   = CW'(HOLD_MAX - 1);
    localparam logic [CW-1:0]      SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, FIRE, WAIT_LOW, WAIT_HIGH, SETTLE, DONE, ERR
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_REQ-1:0] ptr_q, ptr_d;
    logic [NUM_REQ-1:0] above, pick;
    logic [NUM_REQ-1:0] grant_d;
    logic               done_d, err_d, busy_d, en_d;
    logic [15:0]        count_d;

    // Pointer is kept one-hot; pick the lowest request at or above it, else wrap
    // to the lowest request overall (x & -x isolates the lowest set bit).
    always_comb begin
        above = req & ~(ptr_q - ONE);
        if (|above) pick = above & (~above + ONE);
        else        pick = req & (~req + ONE);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        grant_d = grant;
        done_d  = 1'b0;
        err_d   = 1'b0;
        busy_d  = busy;
        en_d    = 1'b0;
        count_d = reset_count;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = FIRE;
                    grant_d = pick;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            FIRE: begin
                state_d = WAIT_LOW;
                cnt_d   = '0;
            end
            WAIT_LOW: begin
                if (!rst_line_in) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == LOW_LAST) begin
                    state_d = ERR;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_HIGH: begin
                if (rst_line_in) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ERR;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE, ERR: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                // Next search starts just past the winner.
                ptr_d   = {grant[NUM_REQ-2:0], grant[NUM_REQ-1]};
                if (state_q == DONE && reset_count != 16'hFFFF)
                    count_d = reset_count + 16'd1;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ptr_q       <= ONE;
            grant       <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b0;
            rst_enable  <= 1'b0;
            reset_count <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            grant       <= grant_d;
            done        <= done_d;
            err         <= err_d;
            busy        <= busy_d;
            rst_enable  <= en_d;
            reset_count <= count_d;
        end
    end
endmodule
